stopwatch_mmss: RTL and testbench

Seconds/minutes stopwatch that sits directly downstream of the 1 s toggle generator. It consumes the generator's toggling `time` output: each transition of that signal is one elapsed second. It keeps an mm:ss count in BCD under start/stop/clear control and drives the digit values to the display-scan stage.

---
 rtl/stopwatch_mmss.sv | 187 ++++++++++++++++++
 tb/tb_stopwatch_mmss.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_mmss.sv
// mm:ss BCD stopwatch driven by the 1 s toggle generator.
// Optional lap freeze is built when STOPWATCH_LAP_EN is defined.
module stopwatch_mmss #(
    parameter int MIN_MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_tgl,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] sec_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       wrap,
    output logic       lap_hold
);

    localparam logic [3:0] MAX_TENS = 4'(MIN_MAX / 10);
    localparam logic [3:0] MAX_ONES = 4'(MIN_MAX % 10);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

    state_t     state;
    logic       tgl_d;
    logic       tick;
    logic       inc;
    logic       at_max;

    logic [3:0] c_so;
    logic [2:0] c_st;
    logic [3:0] c_mo;
    logic [3:0] c_mt;

    logic [3:0] n_so;
    logic [2:0] n_st;
    logic [3:0] n_mo;
    logic [3:0] n_mt;
    logic       n_wrap;

    assign tick   = tick_tgl ^ tgl_d;
    assign inc    = (state == RUN) && tick;
    assign at_max = (c_mt == MAX_TENS) && (c_mo == MAX_ONES)
                 && (c_st == 3'd5) && (c_so == 4'd9);

    // Next live count: clear first, then BCD cascade on a counted tick
    always_comb begin
        n_so   = c_so;
        n_st   = c_st;
        n_mo   = c_mo;
        n_mt   = c_mt;
        n_wrap = 1'b0;
        if (clear) begin
            n_so = '0;
            n_st = '0;
            n_mo = '0;
            n_mt = '0;
        end else if (inc) begin
            if (at_max) begin
                n_so   = '0;
                n_st   = '0;
                n_mo   = '0;
                n_mt   = '0;
                n_wrap = 1'b1;
            end else if (c_so != 4'd9) begin
                n_so = c_so + 4'd1;
            end else begin
                n_so = '0;
                if (c_st != 3'd5) begin
                    n_st = c_st + 3'd1;
                end else begin
                    n_st = '0;
                    if (c_mo != 4'd9) begin
                        n_mo = c_mo + 4'd1;
                    end else begin
                        n_mo = '0;
                        n_mt = c_mt + 4'd1;
                    end
                end
            end
        end
    end

    // Control FSM, toggle edge register, live count and wrap pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            running <= 1'b0;
            wrap    <= 1'b0;
            tgl_d   <= 1'b0;
            c_so    <= '0;
            c_st    <= '0;
            c_mo    <= '0;
            c_mt    <= '0;
        end else begin
            tgl_d <= tick_tgl;
            c_so  <= n_so;
            c_st  <= n_st;
            c_mo  <= n_mo;
            c_mt  <= n_mt;
            wrap  <= n_wrap;
            if (clear) begin
                state   <= IDLE;
                running <= 1'b0;
            end else if (start_stop) begin
                case (state)
                    IDLE: begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                    RUN: begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                    PAUSE: begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic       hold;
    logic       lap_ok;
    logic [3:0] o_so;
    logic [2:0] o_st;
    logic [3:0] o_mo;
    logic [3:0] o_mt;

    assign lap_ok = lap && (state != IDLE);

    // Display shadow: follows the live count unless a lap freeze is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= 1'b0;
            o_so <= '0;
            o_st <= '0;
            o_mo <= '0;
            o_mt <= '0;
        end else if (clear) begin
            hold <= 1'b0;
            o_so <= '0;
            o_st <= '0;
            o_mo <= '0;
            o_mt <= '0;
        end else begin
            if (lap_ok) begin
                hold <= ~hold;
            end
            if (!hold || lap_ok) begin
                o_so <= n_so;
                o_st <= n_st;
                o_mo <= n_mo;
                o_mt <= n_mt;
            end
        end
    end

    assign sec_ones = o_so;
    assign sec_tens = o_st;
    assign min_ones = o_mo;
    assign min_tens = o_mt;
    assign lap_hold = hold;
`else
    logic unused_lap;

    assign unused_lap = lap;
    assign sec_ones   = c_so;
    assign sec_tens   = c_st;
    assign min_ones   = c_mo;
    assign min_tens   = c_mt;
    assign lap_hold   = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_mmss.sv
// Bench for stopwatch_mmss: vector table, corner sequences and
// random traffic against a total-seconds reference model.
module tb_stopwatch_mmss;

    localparam int MM = 3;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_tgl;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] sec_ones;
    logic [2:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       wrap;
    logic       lap_hold;

    int checks = 0;
    int errors = 0;

    // reference model: whole seconds, 0 idle / 1 run / 2 pause
    int m_total;
    int m_state;
    int m_disp;
    bit m_wrap;
    bit m_hold;
    bit m_tgl;

    typedef struct {
        bit ss;
        bit clr;
        bit tg;
        int sec;
        bit run;
    } vec_t;

    vec_t vecs[13];

    stopwatch_mmss #(.MIN_MAX(MM)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_tgl  (tick_tgl),
        .start_stop(start_stop),
        .clear     (clear),
        .lap       (lap),
        .sec_ones  (sec_ones),
        .sec_tens  (sec_tens),
        .min_ones  (min_ones),
        .min_tens  (min_tens),
        .running   (running),
        .wrap      (wrap),
        .lap_hold  (lap_hold)
    );

    always #10 clk = ~clk;

    task automatic expv(input string nm, input int mm, input int ss,
                        input bit run, input bit wr, input bit hd);
        logic [18:0] got;
        logic [18:0] exp;
        got = {min_tens, min_ones, 1'b0, sec_tens, sec_ones,
               running, wrap, lap_hold};
        exp = {4'(mm / 10), 4'(mm % 10), 1'b0, 3'(ss / 10),
               4'(ss % 10), run, wr, hd};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (%0d:%0d run %0b wrap %0b hold %0b)",
                     nm, got, exp, mm, ss, run, wr, hd);
        end
    endtask

    task automatic model_reset();
        m_total = 0;
        m_state = 0;
        m_disp  = 0;
        m_wrap  = 1'b0;
        m_hold  = 1'b0;
        m_tgl   = 1'b0;
    endtask

    task automatic model_step(input bit ss, input bit clr, input bit lp);
        bit tk;
        tk     = (tick_tgl != m_tgl);
        m_tgl  = tick_tgl;
        m_wrap = 1'b0;
        if (clr) begin
            m_total = 0;
            m_state = 0;
            m_hold  = 1'b0;
            m_disp  = 0;
        end else begin
            if (m_state == 1 && tk) begin
                m_total++;
                if (m_total == (MM + 1) * 60) begin
                    m_total = 0;
                    m_wrap  = 1'b1;
                end
            end
            if (LAP && lp && m_state != 0) begin
                m_hold = !m_hold;
                m_disp = m_total;
            end
            if (ss) m_state = (m_state == 1) ? 2 : 1;
            if (!m_hold) m_disp = m_total;
        end
    endtask

    task automatic cyc(input bit ss, input bit clr, input bit lp,
                       input bit tg, input string nm);
        start_stop = ss;
        clear      = clr;
        lap        = lp;
        if (tg) tick_tgl = ~tick_tgl;
        @(posedge clk);
        model_step(ss, clr, lp);
        #1;
        expv(nm, m_disp / 60, m_disp % 60, m_state == 1, m_wrap, m_hold);
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
    endtask

    task automatic ticks(input int n, input string nm);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, nm);
    endtask

    task automatic restart();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "clr");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "start");
    endtask

    initial begin
        vecs = '{
            '{1'b1, 1'b0, 1'b1, 0, 1'b1},
            '{1'b0, 1'b0, 1'b1, 1, 1'b1},
            '{1'b0, 1'b0, 1'b1, 2, 1'b1},
            '{1'b0, 1'b0, 1'b0, 2, 1'b1},
            '{1'b1, 1'b0, 1'b0, 2, 1'b0},
            '{1'b0, 1'b0, 1'b1, 2, 1'b0},
            '{1'b1, 1'b0, 1'b0, 2, 1'b1},
            '{1'b1, 1'b0, 1'b1, 3, 1'b0},
            '{1'b1, 1'b1, 1'b1, 0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 0, 1'b1},
            '{1'b0, 1'b0, 1'b1, 1, 1'b1},
            '{1'b0, 1'b1, 1'b1, 0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 0, 1'b0}
        };

        rst        = 1'b1;
        tick_tgl   = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        expv("reset", 0, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            cyc(vecs[i].ss, vecs[i].clr, 1'b0, vecs[i].tg, "vec_model");
            expv("vec", 0, vecs[i].sec, vecs[i].run, 1'b0, 1'b0);
        end

        restart();
        ticks(75, "basic");
        expv("basic_0115", 1, 15, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "pause");
        ticks(5, "paused");
        expv("pause_0115", 1, 15, 1'b0, 1'b0, 1'b0);

        restart();
        ticks(9, "to9");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, "ss_tick");
        expv("ss_tick_0010", 0, 10, 1'b0, 1'b0, 1'b0);

        restart();
        ticks(MM * 60 + 59, "to_max");
        expv("at_max", MM, 59, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "wrap_m");
        expv("wrap", 0, 0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "wrap_end_m");
        expv("wrap_end", 0, 0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "after_wrap_m");
        expv("after_wrap", 0, 1, 1'b1, 1'b0, 1'b0);

        restart();
        ticks(20, "to20");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, "lap_on");
        ticks(10, "lap_run");
        expv("lap_frozen", 0, LAP ? 20 : 30, 1'b1, 1'b0, LAP);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, "lap_off");
        expv("lap_release", 0, 30, 1'b1, 1'b0, 1'b0);

        restart();
        repeat (3000) begin
            cyc($urandom_range(15) == 0, $urandom_range(127) == 0,
                $urandom_range(15) == 0, 1'($urandom_range(1)), "rand");
        end

        restart();
        ticks(207, "to327");
        expv("at_0327", 3, 27, 1'b1, 1'b0, 1'b0);
        #4;
        rst = 1'b1;
        #1;
        expv("rst_async", 0, 0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "rst_tick_m");
        expv("rst_tick", 0, 0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
